// File: rtl/pwm_pkg.sv
// Shared types and constants for the multi-channel PWM bank.
package pwm_pkg;

  typedef enum logic {
    MODE_EDGE   = 1'b0,
    MODE_CENTER = 1'b1
  } mode_t;

  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } dir_t;

  localparam int unsigned ADDR_TOP   = 0;
  localparam int unsigned ADDR_MODE  = 1;
  localparam int unsigned ADDR_DUTY0 = 2;

  // Widest supported WIDTH; users truncate to their own width.
  localparam logic [15:0] TOP_RST  = 16'hFFFF;
  localparam logic [15:0] DUTY_RST = 16'h0000;

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: double-buffered duty, compare against the shared counter, polarity.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             we,
  input  logic [WIDTH-1:0] wdata,
  input  logic             load,
  input  logic [WIDTH-1:0] cnt,
  input  logic             pol,
  output logic             pwm_out
);

  logic [WIDTH-1:0] duty_s;
  logic [WIDTH-1:0] duty_a;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      duty_s  <= WIDTH'(DUTY_RST);
      duty_a  <= WIDTH'(DUTY_RST);
      pwm_out <= 1'b0;
    end else begin
      if (we)   duty_s <= wdata;
      // Load uses the pre-write staging value when both land on the same edge.
      if (load) duty_a <= duty_s;
      if (en)   pwm_out <= (cnt < duty_a) ^ pol;
    end
  end

endmodule

// File: rtl/pwm_bank.sv
// Multi-channel PWM: shared prescaler and edge/center counter, shadowed TOP/mode, N channels.
module pwm_bank
  import pwm_pkg::*;
#(
  parameter  int unsigned CHANNELS   = 4,
  parameter  int unsigned WIDTH      = 8,
  parameter  int unsigned PRESCALE_W = 8,
  localparam int unsigned AW         = $clog2(CHANNELS + 2)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [CHANNELS-1:0]   pol,
  input  logic                  cfg_we,
  input  logic [AW-1:0]         cfg_addr,
  input  logic [WIDTH-1:0]      cfg_wdata,
  output logic [CHANNELS-1:0]   pwm_out,
  output logic                  period_strobe
);

  logic [PRESCALE_W-1:0] psc;
  logic                  tick;
  logic                  load;
  logic [WIDTH-1:0]      cnt, cnt_nxt;
  dir_t                  dir, dir_nxt;
  logic [WIDTH-1:0]      top_s, top_a;
  mode_t                 mode_s, mode_a;

  // >= keeps ticking sane if prescale is lowered below the running count.
  assign tick = en && (psc >= prescale);
  assign load = tick && (cnt_nxt == '0);

  always_comb begin
    cnt_nxt = '0;
    dir_nxt = UP;
    if (mode_a == MODE_EDGE) begin
      if (cnt < top_a) cnt_nxt = cnt + 1'b1;
    end else if (dir == UP) begin
      if (cnt < top_a) begin
        cnt_nxt = cnt + 1'b1;
      end else if (top_a > WIDTH'(1)) begin
        cnt_nxt = top_a - 1'b1;
        dir_nxt = DOWN;
      end
    end else begin
      cnt_nxt = cnt - 1'b1;
      dir_nxt = (cnt > WIDTH'(1)) ? DOWN : UP;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      psc           <= '0;
      cnt           <= '0;
      dir           <= UP;
      period_strobe <= 1'b0;
    end else begin
      period_strobe <= load;
      if (en)   psc <= tick ? '0 : psc + 1'b1;
      if (tick) begin
        cnt <= cnt_nxt;
        dir <= dir_nxt;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      top_s  <= WIDTH'(TOP_RST);
      top_a  <= WIDTH'(TOP_RST);
      mode_s <= MODE_EDGE;
      mode_a <= MODE_EDGE;
    end else begin
      if (cfg_we && cfg_addr == AW'(ADDR_TOP))  top_s  <= cfg_wdata;
      if (cfg_we && cfg_addr == AW'(ADDR_MODE)) mode_s <= mode_t'(cfg_wdata[0]);
      if (load) begin
        top_a  <= top_s;
        mode_a <= mode_s;
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    pwm_channel #(
      .WIDTH(WIDTH)
    ) u_ch (
      .clk    (clk),
      .reset  (reset),
      .en     (en),
      .we     (cfg_we && (cfg_addr == AW'(ADDR_DUTY0 + g))),
      .wdata  (cfg_wdata),
      .load   (load),
      .cnt    (cnt),
      .pol    (pol[g]),
      .pwm_out(pwm_out[g])
    );
  end

endmodule

// File: tb/tb_pwm_bank.sv
// Bench for pwm_bank: per-cycle reference model based on period phase, plus directed duty/period counts.
module tb_pwm_bank;

  localparam int unsigned CH = 4;
  localparam int unsigned W  = 8;
  localparam int unsigned PW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic [PW-1:0] prescale;
  logic [CH-1:0] pol;
  logic          cfg_we;
  logic [2:0]    cfg_addr;
  logic [W-1:0]  cfg_wdata;
  logic [CH-1:0] pwm_out;
  logic          period_strobe;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: period phase index plus shadow/active configuration.
  int            m_psc, m_pos, m_top_s, m_top_a, m_mode_s, m_mode_a;
  int            m_duty_s[CH];
  int            m_duty_a[CH];
  logic [CH-1:0] exp_out;
  logic          exp_strobe;
  int            hi[CH];
  int            n_strobe;
  int            nsteps;

  pwm_bank #(
    .CHANNELS  (CH),
    .WIDTH     (W),
    .PRESCALE_W(PW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .prescale     (prescale),
    .pol          (pol),
    .cfg_we       (cfg_we),
    .cfg_addr     (cfg_addr),
    .cfg_wdata    (cfg_wdata),
    .pwm_out      (pwm_out),
    .period_strobe(period_strobe)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_psc = 0; m_pos = 0;
    m_top_s = 255; m_top_a = 255;
    m_mode_s = 0; m_mode_a = 0;
    for (int i = 0; i < CH; i++) begin
      m_duty_s[i] = 0;
      m_duty_a[i] = 0;
    end
    exp_out = '0;
    exp_strobe = 1'b0;
  endtask

  function automatic int period_len();
    if (m_mode_a == 0) return m_top_a + 1;
    return (m_top_a == 0) ? 1 : 2 * m_top_a;
  endfunction

  function automatic bit next_is_load();
    bit tk;
    tk = en && (m_psc >= int'(prescale));
    return tk && (((m_pos + 1) % period_len()) == 0);
  endfunction

  task automatic model_edge();
    int cnt, a;
    bit tk, ld;
    logic [CH-1:0] nxt;
    cnt = (m_mode_a == 0 || m_pos <= m_top_a) ? m_pos : 2 * m_top_a - m_pos;
    nxt = exp_out;
    if (en)
      for (int i = 0; i < CH; i++) nxt[i] = (cnt < m_duty_a[i]) ^ pol[i];
    tk = en && (m_psc >= int'(prescale));
    ld = 1'b0;
    if (tk) begin
      m_pos = (m_pos + 1) % period_len();
      ld = (m_pos == 0);
    end
    if (en) m_psc = tk ? 0 : m_psc + 1;
    if (ld) begin
      m_top_a = m_top_s;
      m_mode_a = m_mode_s;
      for (int i = 0; i < CH; i++) m_duty_a[i] = m_duty_s[i];
    end
    if (cfg_we) begin
      a = int'(cfg_addr);
      if (a == 0) m_top_s = int'(cfg_wdata);
      else if (a == 1) m_mode_s = int'(cfg_wdata[0]);
      else if (a < 2 + CH) m_duty_s[a-2] = int'(cfg_wdata);
    end
    exp_out = nxt;
    exp_strobe = ld;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check("pwm_out", 32'(pwm_out), 32'(exp_out));
    check("period_strobe", 32'(period_strobe), 32'(exp_strobe));
    cfg_we = 1'b0;
  endtask

  task automatic wr(input int addr, input int data);
    cfg_we = 1'b1;
    cfg_addr = 3'(addr);
    cfg_wdata = W'(data);
    step();
  endtask

  task automatic wait_strobe(input int bound, output int steps);
    steps = 0;
    do begin
      step();
      steps++;
    end while (!period_strobe && steps < bound);
    check("strobe_wait", 32'(period_strobe), 32'd1);
  endtask

  task automatic measure(input int n);
    for (int i = 0; i < CH; i++) hi[i] = 0;
    n_strobe = 0;
    for (int k = 0; k < n; k++) begin
      step();
      for (int i = 0; i < CH; i++) hi[i] += int'(pwm_out[i]);
      n_strobe += int'(period_strobe);
    end
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; prescale = '0; pol = 4'b1111;
    cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    model_reset();
    @(posedge clk); #1;
    check("reset_pwm", 32'(pwm_out), 32'd0);
    check("reset_strobe", 32'(period_strobe), 32'd0);

    // Reset values: duty 0 inverted, TOP 255.
    reset = 1'b0; en = 1'b1;
    for (int k = 0; k < 20; k++) step();
    check("rel_pwm_inv", 32'(pwm_out), 32'hF);

    // Edge mode with extremes.
    pol = '0;
    wr(0, 9); wr(2, 3); wr(3, 0); wr(4, 10); wr(5, 255);
    wait_strobe(600, nsteps);
    measure(30);
    check("edge_hi0", hi[0], 9);
    check("edge_strobes", n_strobe, 3);
    check("edge_hi1", hi[1], 0);
    check("edge_hi2", hi[2], 30);
    check("edge_hi3", hi[3], 30);
    pol = 4'b0100;
    step();
    check("pol2_out", 32'(pwm_out[2]), 32'd0);
    measure(10);
    check("pol2_hi2", hi[2], 0);

    // Center mode.
    pol = '0;
    wr(1, 1); wr(0, 5); wr(2, 2);
    wait_strobe(40, nsteps);
    measure(20);
    check("ctr_hi0_d2", hi[0], 6);
    check("ctr_strobes", n_strobe, 2);
    wr(2, 5);
    wait_strobe(40, nsteps);
    measure(20);
    check("ctr_hi0_d5", hi[0], 18);

    // Shadowing: write landing on a load edge applies one period later.
    wr(2, 7);
    for (int k = 0; k < 20 && !next_is_load(); k++) step();
    wr(2, 1);
    measure(10);
    check("shadow_old", hi[0], 10);
    measure(10);
    check("shadow_new", hi[0], 1);

    // Prescaled edge mode.
    prescale = 8'd2;
    wr(1, 0); wr(0, 9); wr(2, 3);
    wait_strobe(200, nsteps);
    measure(60);
    check("psc_hi0", hi[0], 18);
    check("psc_strobes", n_strobe, 2);

    // Freeze.
    en = 1'b0;
    pol = 4'b1010;
    measure(20);
    check("freeze_strobes", n_strobe, 0);
    en = 1'b1;

    // Randomized traffic, including TOP = 0 and random polarity/prescale.
    for (int k = 0; k < 400; k++) begin
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) pol = CH'($urandom);
      if ($urandom_range(0, 39) == 0) prescale = PW'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        cfg_we = 1'b1;
        cfg_addr = 3'($urandom_range(0, 7));
        cfg_wdata = (cfg_addr == 3'd0) ? W'($urandom_range(0, 12)) : W'($urandom_range(0, 15));
      end
      step();
    end

    // Asynchronous reset mid-period.
    en = 1'b1; prescale = '0; pol = 4'b0101;
    reset = 1'b1;
    #1;
    check("midrst_pwm", 32'(pwm_out), 32'd0);
    check("midrst_strobe", 32'(period_strobe), 32'd0);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    step();
    check("postrst_pol", 32'(pwm_out), 32'(pol));
    wait_strobe(300, nsteps);
    check("postrst_period", nsteps, 255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_bank.md
# pwm_bank

Parametrised multi-channel PWM generator and the successor to the single-channel, fixed 8-bit PWM. All channels share one prescaled period counter. Software writes a period (TOP), a mode and per-channel duty values through a simple write port. These values are double-buffered and applied only at period boundaries, so updates never glitch. It supports edge-aligned and center-aligned modes, per-channel output polarity and a period strobe for system sync.

## Interface
- CHANNELS, 4: number of PWM outputs (1..16)
- WIDTH, 8: counter, TOP and duty width (4..16)
- PRESCALE_W, 8: prescaler reload width
- clk  in  1  sole clock
- reset  in  1  asynchronous, active-high reset
- en  in  1  1 = counter advances on ticks; 0 = counter, prescaler and outputs hold
- prescale  in  PRESCALE_W  tick every prescale+1 clk cycles; sampled continuously
- pol  in  CHANNELS  per-channel polarity; 1 inverts the output
- cfg_we  in  1  write strobe
- cfg_addr  in  AW=$clog2(CHANNELS+2)  0 = TOP, 1 = mode (bit0: 0 edge, 1 center), 2+i = duty of channel i
- cfg_wdata  in  WIDTH  write data
- pwm_out  out  CHANNELS  registered PWM outputs
- period_strobe  out  1  one-clk pulse at each period start

## Operation
- Staging registers hold TOP, mode and duty[i]; cfg_we writes them in the same cycle. Addresses above CHANNELS+1 are ignored. Unused mode bits are ignored.
- Active registers are copied from staging at the load point. The load point is the tick on which the counter becomes 0.
- If a write and a load point fall on the same edge, the active register takes the pre-write staging value. The new value applies at the following load point.
- Prescaler: counts 0..prescale and issues a tick when it reaches prescale, then returns to 0. With prescale = 0, every cycle is a tick.
- Edge mode: the counter runs 0,1,…,TOP then wraps to 0. The period is TOP+1 ticks. A channel is active while cnt < duty.
- Center mode: the counter runs 0 up to TOP, then TOP-1 down to 1, then returns to 0. The period is 2·TOP ticks. A channel is active while cnt < duty, which gives 2·duty−1 active ticks centered on cnt = 0 for 1 ≤ duty ≤ TOP.
- Boundaries:
  - duty = 0 gives a constant inactive output.
  - duty > TOP gives a constant active output (100%).
  - TOP = 0 in either mode: the counter stays at 0, every tick is a load point, and only duty = 0 or duty > 0 matters.
- A mode change at a load point restarts counting upward from 0.
- pwm_out[i] = active[i] XOR pol[i].
- Reset values:
  - counter, prescaler and direction are 0 / up.
  - staging and active TOP = 2^WIDTH−1, mode = edge, duty = 0.
  - pwm_out = 0 and period_strobe = 0 regardless of pol.
- Reset mid-period aborts the period immediately. All registers return to their reset values.

## Timing
- Counter and direction update on clk edges where en && tick.
- pwm_out and period_strobe are registered and reflect the previous cycle's counter value and active registers, a 1-cycle latency.
- period_strobe is high for exactly one clk in the cycle after a load point. With en = 0 it stays 0.
- After reset release, the first tick with en = 1 moves the counter to 1. The first load point follows at the next wrap, i.e. the first period after reset uses reset values.
- A pol change is visible on pwm_out one cycle later, with no period alignment.

## Structure
- Package pwm_pkg holds:
  - a mode enum (MODE_EDGE = 0, MODE_CENTER = 1);
  - address constants ADDR_TOP = 0, ADDR_MODE = 1, ADDR_DUTY0 = 2;
  - reset constants for TOP and duty.
- Top-level pwm_bank contains the prescaler, the shared counter/direction FSM (UP, DOWN), the staging and active TOP/mode registers, and the load-point generation.
- Sub-module pwm_channel is instantiated CHANNELS times. Each instance holds its own staging/active duty, the compare and the polarity/output register.

## Test plan
- Reset: assert reset with pol = 4'b1111 → pwm_out = 0 and period_strobe = 0. Release with en = 1 and no writes → pwm_out = 4'b1111 (duty 0, inverted) from the second cycle onward.
- Edge mode: WIDTH = 8, TOP = 9, duty0 = 3, prescale = 0. After the first period_strobe, pwm_out[0] is high 3 of every 10 cycles, and period_strobe repeats every 10 cycles.
- Extremes: TOP = 9 with duty1 = 0, duty2 = 10 and duty3 = 255 → ch1 constant 0, ch2 and ch3 constant 1. Setting pol[2] = 1 → ch2 constant 0 one cycle later.
- Center mode: TOP = 5, duty0 = 2 → period 10 cycles, pwm_out[0] high 3 contiguous cycles around cnt = 0. duty0 = 5 → high 9 of 10.
- Shadowing: mid-period write duty0 = 7 → output unchanged until the next load point. A write on the load-point edge takes effect one period later.
- Prescale/en/reset: prescale = 2 and TOP = 9 → period 30 clks. en = 0 freezes the counter and pwm_out. Reset mid-period → all outputs 0, and the registers read back their reset behaviour afterwards.
